// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single-port data BRAM between the core
// memory stage and an auxiliary requester (loader / DMA).
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_core_*             core request, byte address, store data, byte enables
//   o_core_stall         core request not granted this cycle
//   o_core_rdata/rvalid  core read return (one cycle after grant)
//   i_aux_*              auxiliary request, address, store data, byte enables
//   o_aux_gnt            auxiliary request accepted this cycle
//   o_aux_rdata/rvalid   auxiliary read return (one cycle after grant)
//   o_mem_*              BRAM port driven by the winner
//   i_mem_rdata          BRAM read data, one cycle after o_mem_en
//   o_conflict_cnt       saturating count of both-request cycles
module dmem_port_arbiter #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 14
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_core_req,
   input  logic [XLEN-1:0]   i_core_adr,
   input  logic [XLEN-1:0]   i_core_wdata,
   input  logic [3:0]        i_core_wea,
   output logic              o_core_stall,
   output logic [XLEN-1:0]   o_core_rdata,
   output logic              o_core_rvalid,
   input  logic              i_aux_req,
   input  logic [XLEN-1:0]   i_aux_adr,
   input  logic [XLEN-1:0]   i_aux_wdata,
   input  logic [3:0]        i_aux_wea,
   output logic              o_aux_gnt,
   output logic [XLEN-1:0]   o_aux_rdata,
   output logic              o_aux_rvalid,
   output logic              o_mem_en,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [XLEN-1:0]   o_mem_wdata,
   output logic [3:0]        o_mem_wea,
   input  logic [XLEN-1:0]   i_mem_rdata,
   output logic [31:0]       o_conflict_cnt
);

   // 0: core preferred on the next conflict, 1: aux preferred
   logic        r_prio;
   logic        r_rd_core;
   logic        r_rd_aux;
   logic [31:0] r_conflict_cnt;

   logic w_both;
   logic w_core_win;
   logic w_aux_win;
   logic w_unused;

   assign w_both = i_core_req & i_aux_req & ~i_rst;

   always_comb begin
      w_core_win = 1'b0;
      w_aux_win  = 1'b0;
      if (!i_rst) begin
         priority case (1'b1)
            w_both: begin
               w_core_win = ~r_prio;
               w_aux_win  = r_prio;
            end
            i_core_req: w_core_win = 1'b1;
            i_aux_req:  w_aux_win  = 1'b1;
            default: begin
               w_core_win = 1'b0;
               w_aux_win  = 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      o_mem_en    = w_core_win | w_aux_win;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      o_mem_wea   = 4'b0000;
      if (w_core_win) begin
         o_mem_addr  = i_core_adr[ADDR_W+1:2];
         o_mem_wdata = i_core_wdata;
         o_mem_wea   = i_core_wea;
      end else if (w_aux_win) begin
         o_mem_addr  = i_aux_adr[ADDR_W+1:2];
         o_mem_wdata = i_aux_wdata;
         o_mem_wea   = i_aux_wea;
      end
   end

   assign o_core_stall = i_core_req & ~w_core_win & ~i_rst;
   assign o_aux_gnt    = w_aux_win;

   // Both sides see the BRAM output; the valid tag says whose it is.
   // Gating with i_rst drops a read granted just before reset.
   assign o_core_rdata  = i_mem_rdata;
   assign o_aux_rdata   = i_mem_rdata;
   assign o_core_rvalid = r_rd_core & ~i_rst;
   assign o_aux_rvalid  = r_rd_aux & ~i_rst;

   assign o_conflict_cnt = r_conflict_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_prio         <= 1'b0;
         r_rd_core      <= 1'b0;
         r_rd_aux       <= 1'b0;
         r_conflict_cnt <= '0;
      end else begin
         r_rd_core <= w_core_win & (i_core_wea == 4'b0000);
         r_rd_aux  <= w_aux_win & (i_aux_wea == 4'b0000);
         // Round-robin: after a conflict, point at the loser
         if (w_both) begin
            r_prio <= w_core_win;
            if (r_conflict_cnt != 32'hFFFF_FFFF)
               r_conflict_cnt <= r_conflict_cnt + 32'd1;
         end
      end
   end

   // Address bits outside the word index are intentionally ignored
   assign w_unused = ^{i_core_adr[XLEN-1:ADDR_W+2], i_core_adr[1:0],
                       i_aux_adr[XLEN-1:ADDR_W+2], i_aux_adr[1:0]};

endmodule
